// File: rtl/rx_acq_ctrl_if.sv
// Recovered-symbol stream seen by the acquisition controller.
//   ce_1M       : one-cycle strobe marking a recovered symbol
//   costas_err  : signed carrier-phase error, valid on ce_1M
//   gardner_err : signed symbol-timing error, valid on ce_1M
//   frame_last  : depacketizer end-of-frame pulse
// master: symbol source (demodulator / depacketizer side)
// slave : rx_acq_ctrl
interface rx_acq_ctrl_if #(
  parameter int ERR_W = 16
);
  logic                    ce_1M;
  logic signed [ERR_W-1:0] costas_err;
  logic signed [ERR_W-1:0] gardner_err;
  logic                    frame_last;

  modport master (
    output ce_1M,
    output costas_err,
    output gardner_err,
    output frame_last
  );

  modport slave (
    input ce_1M,
    input costas_err,
    input gardner_err,
    input frame_last
  );
endinterface

// File: rtl/rx_acq_ctrl.sv
// Receiver acquisition controller: resets the Costas/Gardner loops, waits for
// them to settle, qualifies lock from the loop error magnitudes, tracks loss of
// lock and drains the depacketizer before forcing a relock.
//
// Ports
//   clk_32M768  : sole clock
//   rst_32M768  : asynchronous active-high reset
//   start       : level enable, low returns to IDLE
//   sym         : symbol stream (ce_1M, costas_err, gardner_err, frame_last)
//   lock_thresh : unsigned error-magnitude threshold for a good symbol
//   settle_len  : symbols to wait after loop reset
//   lock_len    : consecutive good symbols to declare lock (0 acts as 1)
//   lost_len    : consecutive bad symbols to declare loss (0 acts as 1)
//   shift_acq   : loop gain shift used while acquiring
//   shift_trk   : loop gain shift used while tracking
//   loop_rst    : loop reset, high for 16 cycles per relock
//   depkt_en    : depacketizer enable (LOCKED, DRAIN)
//   locked      : lock indication (LOCKED only)
//   loop_shift  : registered loop gain shift
//   state       : IDLE=0 LRST=1 SETTLE=2 ACQUIRE=3 LOCKED=4 DRAIN=5
//   relock_cnt  : saturating relock counter, cleared only by reset
//
// Build option: define RX_ACQ_GEARSHIFT_EN to switch loop_shift between
// shift_acq (acquisition states) and shift_trk (LOCKED/DRAIN). Without it
// loop_shift is always shift_trk outside reset.
module rx_acq_ctrl #(
  parameter int ERR_W       = 16,
  parameter int TIMEOUT_SYM = 1024
) (
  input  logic             clk_32M768,
  input  logic             rst_32M768,
  input  logic             start,
  rx_acq_ctrl_if.slave     sym,
  input  logic [ERR_W-2:0] lock_thresh,
  input  logic [15:0]      settle_len,
  input  logic [7:0]       lock_len,
  input  logic [7:0]       lost_len,
  input  logic [3:0]       shift_acq,
  input  logic [3:0]       shift_trk,
  output logic             loop_rst,
  output logic             depkt_en,
  output logic             locked,
  output logic [3:0]       loop_shift,
  output logic [2:0]       state,
  output logic [7:0]       relock_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LRST    = 3'd1,
    SETTLE  = 3'd2,
    ACQUIRE = 3'd3,
    LOCKED  = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT_SYM);
  localparam logic [16:0] DRAIN_LIM   = 17'd64;

  // |x| with the most-negative code clamped so it still fits ERR_W-1 bits.
  function automatic logic [ERR_W-2:0] sat_abs(input logic signed [ERR_W-1:0] x);
    logic signed [ERR_W-1:0] neg;
    if (x[ERR_W-1] && (x[ERR_W-2:0] == '0)) begin
      sat_abs = '1;
    end else if (x[ERR_W-1]) begin
      neg     = -x;
      sat_abs = neg[ERR_W-2:0];
    end else begin
      sat_abs = x[ERR_W-2:0];
    end
  endfunction

  state_t      state_q, state_nxt;
  logic [3:0]  lrst_cnt, lrst_nxt;
  logic [15:0] sym_cnt, sym_nxt;
  logic [7:0]  run_cnt, run_nxt;
  logic        relock_inc;

  logic        good;
  logic [7:0]  lock_tgt, lost_tgt;
  logic [16:0] sym_inc;
  logic [8:0]  run_inc;

  assign good     = (sat_abs(sym.costas_err) <= lock_thresh) &&
                    (sat_abs(sym.gardner_err) <= lock_thresh);
  assign lock_tgt = (lock_len == 8'd0) ? 8'd1 : lock_len;
  assign lost_tgt = (lost_len == 8'd0) ? 8'd1 : lost_len;
  assign sym_inc  = {1'b0, sym_cnt} + 17'd1;
  assign run_inc  = {1'b0, run_cnt} + 9'd1;
  assign state    = state_q;

  // Every state change clears all counters, so a strobe that triggers an exit
  // is never counted in the state being entered.
  always_comb begin
    state_nxt  = state_q;
    lrst_nxt   = lrst_cnt;
    sym_nxt    = sym_cnt;
    run_nxt    = run_cnt;
    relock_inc = 1'b0;

    if (!start) begin
      state_nxt = IDLE;
      lrst_nxt  = '0;
      sym_nxt   = '0;
      run_nxt   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_nxt = LRST;
          lrst_nxt  = '0;
          sym_nxt   = '0;
          run_nxt   = '0;
        end
        LRST: begin
          if (lrst_cnt == 4'd15) begin
            state_nxt = SETTLE;
            lrst_nxt  = '0;
          end else begin
            lrst_nxt = lrst_cnt + 4'd1;
          end
        end
        SETTLE: begin
          if (sym.ce_1M) begin
            if (sym_inc >= {1'b0, settle_len}) begin
              state_nxt = ACQUIRE;
              sym_nxt   = '0;
              run_nxt   = '0;
            end else begin
              sym_nxt = sym_inc[15:0];
            end
          end
        end
        ACQUIRE: begin
          if (sym.ce_1M) begin
            // A locking symbol wins over a timeout landing on the same strobe.
            if (good && (run_inc >= {1'b0, lock_tgt})) begin
              state_nxt = LOCKED;
              sym_nxt   = '0;
              run_nxt   = '0;
            end else if (sym_inc >= TIMEOUT_LIM) begin
              state_nxt  = LRST;
              sym_nxt    = '0;
              run_nxt    = '0;
              lrst_nxt   = '0;
              relock_inc = 1'b1;
            end else begin
              sym_nxt = sym_inc[15:0];
              run_nxt = good ? run_inc[7:0] : 8'd0;
            end
          end
        end
        LOCKED: begin
          if (sym.ce_1M) begin
            if (good) begin
              run_nxt = '0;
            end else if (run_inc >= {1'b0, lost_tgt}) begin
              state_nxt = DRAIN;
              sym_nxt   = '0;
              run_nxt   = '0;
            end else begin
              run_nxt = run_inc[7:0];
            end
          end
        end
        DRAIN: begin
          if (sym.frame_last || (sym.ce_1M && (sym_inc >= DRAIN_LIM))) begin
            state_nxt  = LRST;
            sym_nxt    = '0;
            run_nxt    = '0;
            lrst_nxt   = '0;
            relock_inc = 1'b1;
          end else if (sym.ce_1M) begin
            sym_nxt = sym_inc[15:0];
          end
        end
        default: begin
          state_nxt = IDLE;
          lrst_nxt  = '0;
          sym_nxt   = '0;
          run_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters and outputs all register from the next-state decode so the
  // outputs line up with the state code.
  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      state_q    <= IDLE;
      lrst_cnt   <= '0;
      sym_cnt    <= '0;
      run_cnt    <= '0;
      relock_cnt <= '0;
      loop_rst   <= 1'b1;
      depkt_en   <= 1'b0;
      locked     <= 1'b0;
      loop_shift <= '0;
    end else begin
      state_q  <= state_nxt;
      lrst_cnt <= lrst_nxt;
      sym_cnt  <= sym_nxt;
      run_cnt  <= run_nxt;
      if (relock_inc && (relock_cnt != 8'hFF)) begin
        relock_cnt <= relock_cnt + 8'd1;
      end
      loop_rst <= (state_nxt == LRST);
      depkt_en <= (state_nxt == LOCKED) || (state_nxt == DRAIN);
      locked   <= (state_nxt == LOCKED);
`ifdef RX_ACQ_GEARSHIFT_EN
      loop_shift <= ((state_nxt == LOCKED) || (state_nxt == DRAIN)) ? shift_trk : shift_acq;
`else
      loop_shift <= shift_trk;
`endif
    end
  end

endmodule
